// File: rtl/setup_chk_pkg.sv
// rtl/setup_chk_pkg.sv - shared types and helpers for the setup capture checker
//
// Purpose: checker state encoding, report record layout and the saturating
//          increment used by every counter in the checker.
// Ports:   none (package).
// Note:    report fields are sized to the widest supported configuration
//          (ID_W and CNT_W up to 16); instances use the low bits.

package setup_chk_pkg;

   localparam int ID_MAX_W  = 16;
   localparam int CNT_MAX_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARM    = 2'd1,
      ST_CHECK  = 2'd2,
      ST_REPORT = 2'd3
   } chk_state_t;

   typedef struct packed {
      logic [ID_MAX_W-1:0]  id;
      logic [CNT_MAX_W-1:0] err_cnt;
      logic [CNT_MAX_W-1:0] samples;
      logic [CNT_MAX_W-1:0] first_err;
      logic                 pass;
   } rpt_t;

   // Increment that sticks at max_v instead of wrapping.
   function automatic logic [CNT_MAX_W-1:0] sat_inc(
      input logic [CNT_MAX_W-1:0] v,
      input logic [CNT_MAX_W-1:0] max_v
   );
      return (v >= max_v) ? max_v : v + 1'b1;
   endfunction

endpackage

// File: rtl/setup_exp_pipe.sv
// rtl/setup_exp_pipe.sv - expected-value delay line for the setup capture checker
//
// Purpose: W-wide, LAT-deep shift register; q is d from LAT clock edges ago.
// Ports:
//   clk    in  1  clock
//   rst_n  in  1  asynchronous active-low clear of every stage
//   d      in  W  zero-delay golden data
//   q      out W  golden data delayed by LAT edges

module setup_exp_pipe #(
   parameter int W   = 1,
   parameter int LAT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage [LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[LAT-1];

endmodule

// File: rtl/setup_capture_checker.sv
// rtl/setup_capture_checker.sv - scores a flop DUT output against a delayed golden copy
//
// Purpose: compares q_obs with d_ref delayed by LAT edges on every CHECK cycle
//          of a case and reports error count, sample count and first-failure
//          index through a valid/ready handshake.
// Optional feature: define SETUP_CHK_XPROP_EN to count any X/Z on q_obs as a
//          mismatch, add the rpt_x_cnt output and require x_cnt==0 for a pass.
// Ports:
//   clk            in  1      clock
//   rst_n          in  1      asynchronous active-low reset
//   d_ref          in  W      data driven into the DUT (pre-delay copy)
//   q_obs          in  W      DUT output under test
//   case_start     in  1      pulse, opens a case (ignored unless idle)
//   case_id        in  ID_W   case label, sampled with case_start
//   case_end       in  1      pulse, closes the case
//   busy           out 1      not idle
//   start_err      out 1      sticky: case_start seen while not idle
//   rpt_valid      out 1      report available
//   rpt_ready      in  1      consumer accepts the report
//   rpt_id         out ID_W   case label
//   rpt_err_cnt    out CNT_W  mismatches, saturating
//   rpt_samples    out CNT_W  compared cycles, saturating
//   rpt_first_err  out CNT_W  1-based sample index of first mismatch, 0 if none
//   rpt_pass       out 1      no errors and at least one sample
//   rpt_x_cnt      out CNT_W  unknown-value samples (SETUP_CHK_XPROP_EN only)

module setup_capture_checker
   import setup_chk_pkg::*;
#(
   parameter int W     = 1,
   parameter int LAT   = 1,
   parameter int CNT_W = 8,
   parameter int ID_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [W-1:0]     d_ref,
   input  logic [W-1:0]     q_obs,
   input  logic             case_start,
   input  logic [ID_W-1:0]  case_id,
   input  logic             case_end,
   output logic             busy,
   output logic             start_err,
   output logic             rpt_valid,
   input  logic             rpt_ready,
   output logic [ID_W-1:0]  rpt_id,
   output logic [CNT_W-1:0] rpt_err_cnt,
   output logic [CNT_W-1:0] rpt_samples,
   output logic [CNT_W-1:0] rpt_first_err,
   output logic             rpt_pass
`ifdef SETUP_CHK_XPROP_EN
   ,
   output logic [CNT_W-1:0] rpt_x_cnt
`endif
);

   localparam int FILL_W = (LAT < 2) ? 1 : $clog2(LAT);
   localparam logic [FILL_W-1:0]    FILL_LAST = FILL_W'(LAT - 1);
   localparam logic [CNT_MAX_W-1:0] CNT_MAX   = CNT_MAX_W'((64'd1 << CNT_W) - 64'd1);

   chk_state_t       state_q, state_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [CNT_W-1:0] smp_q, smp_d;
   logic [CNT_W-1:0] first_q, first_d;
   logic             start_err_q, start_err_d;
   logic             mismatch;
   logic [W-1:0]     exp_q;
`ifdef SETUP_CHK_XPROP_EN
   logic [CNT_W-1:0] x_q, x_d;
   logic             x_seen;
`endif

   setup_exp_pipe #(
      .W   (W),
      .LAT (LAT)
   ) u_exp_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d_ref),
      .q     (exp_q)
   );

   // In the default build an unknown q_obs makes the compare unknown, which
   // the if below treats as a match; only a resolved difference counts.
`ifdef SETUP_CHK_XPROP_EN
   assign x_seen   = $isunknown(q_obs);
   assign mismatch = x_seen || (q_obs != exp_q);
`else
   assign mismatch = (q_obs != exp_q);
`endif

   always_comb begin
      state_d     = state_q;
      fill_d      = fill_q;
      id_d        = id_q;
      err_d       = err_q;
      smp_d       = smp_q;
      first_d     = first_q;
      start_err_d = start_err_q;
`ifdef SETUP_CHK_XPROP_EN
      x_d         = x_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            // A simultaneous case_end is dropped: the start opens the case.
            if (case_start) begin
               state_d = ST_ARM;
               id_d    = case_id;
               fill_d  = '0;
               err_d   = '0;
               smp_d   = '0;
               first_d = '0;
`ifdef SETUP_CHK_XPROP_EN
               x_d     = '0;
`endif
            end
         end
         ST_ARM: begin
            // Wait for the pipe to hold data captured inside this case.
            if (case_end)
               state_d = ST_REPORT;
            else if (fill_q == FILL_LAST)
               state_d = ST_CHECK;
            else
               fill_d = fill_q + 1'b1;
         end
         ST_CHECK: begin
            smp_d = CNT_W'(sat_inc(CNT_MAX_W'(smp_q), CNT_MAX));
            if (mismatch) begin
               err_d = CNT_W'(sat_inc(CNT_MAX_W'(err_q), CNT_MAX));
               if (err_q == '0) first_d = CNT_W'(sat_inc(CNT_MAX_W'(smp_q), CNT_MAX));
            end
`ifdef SETUP_CHK_XPROP_EN
            if (x_seen) x_d = CNT_W'(sat_inc(CNT_MAX_W'(x_q), CNT_MAX));
`endif
            if (case_end) state_d = ST_REPORT;
         end
         ST_REPORT: begin
            if (rpt_ready) state_d = ST_IDLE;
         end
      endcase

      if (case_start && (state_q != ST_IDLE)) start_err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         fill_q      <= '0;
         id_q        <= '0;
         err_q       <= '0;
         smp_q       <= '0;
         first_q     <= '0;
         start_err_q <= 1'b0;
`ifdef SETUP_CHK_XPROP_EN
         x_q         <= '0;
`endif
      end else begin
         state_q     <= state_d;
         fill_q      <= fill_d;
         id_q        <= id_d;
         err_q       <= err_d;
         smp_q       <= smp_d;
         first_q     <= first_d;
         start_err_q <= start_err_d;
`ifdef SETUP_CHK_XPROP_EN
         x_q         <= x_d;
`endif
      end
   end

   rpt_t rpt_s;
   logic pass_c;
   logic unused_rpt;

`ifdef SETUP_CHK_XPROP_EN
   assign pass_c = (err_q == '0) && (smp_q != '0) && (x_q == '0);
   assign rpt_x_cnt = x_q;
`else
   assign pass_c = (err_q == '0) && (smp_q != '0);
`endif

   always_comb begin
      rpt_s           = '0;
      rpt_s.id        = ID_MAX_W'(id_q);
      rpt_s.err_cnt   = CNT_MAX_W'(err_q);
      rpt_s.samples   = CNT_MAX_W'(smp_q);
      rpt_s.first_err = CNT_MAX_W'(first_q);
      rpt_s.pass      = pass_c;
   end

   // Report fields come straight from registers that are frozen in REPORT,
   // so they stay stable for as long as the consumer stalls.
   assign rpt_id        = rpt_s.id[ID_W-1:0];
   assign rpt_err_cnt   = rpt_s.err_cnt[CNT_W-1:0];
   assign rpt_samples   = rpt_s.samples[CNT_W-1:0];
   assign rpt_first_err = rpt_s.first_err[CNT_W-1:0];
   assign rpt_pass      = rpt_s.pass;
   assign unused_rpt    = ^rpt_s;

   assign busy      = (state_q != ST_IDLE);
   assign rpt_valid = (state_q == ST_REPORT);
   assign start_err = start_err_q;

endmodule
